// File: rtl/joystick_pkg.sv
// joystick_pkg: shared state encoding, joystick bit map and frame reordering for the serial reader.
package joystick_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;
  localparam int SCAN_BITS = 16;
  // Sample k lands in joy1[7-k] for k<8 and joy2[15-k] otherwise; result is {joy2, joy1}.
  function automatic logic [SCAN_BITS-1:0] order_frame(input logic [SCAN_BITS-1:0] s);
    logic [SCAN_BITS-1:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f[7-k]  = s[k];
      f[15-k] = s[k+8];
    end
    return f;
  endfunction
endpackage

// File: rtl/joystick_serial_reader.sv
// joystick_serial_reader: scans a 74HC165-style chain into two debounced active-high joystick words.
module joystick_serial_reader
  import joystick_pkg::*;
#(
  parameter int LOAD_TICKS = 2,
  parameter int HALF_TICKS = 2,
  parameter int GAP_TICKS  = 189
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       joyD,
  output logic       joyCk,
  output logic       joyLd,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       strobe
);
  localparam int MAXT = (GAP_TICKS > LOAD_TICKS)
                        ? ((GAP_TICKS > HALF_TICKS) ? GAP_TICKS : HALF_TICKS)
                        : ((LOAD_TICKS > HALF_TICKS) ? LOAD_TICKS : HALF_TICKS);
  localparam int TW = $clog2(MAXT + 1);
  state_t                 r_state;
  logic [TW-1:0]          r_tick;
  logic [3:0]             r_bit;
  logic [SCAN_BITS-1:0]   r_sr;
  logic [SCAN_BITS-1:0]   r_prev;
  logic [7:0]             r_joy1;
  logic [7:0]             r_joy2;
  logic                   r_strobe;
  logic [TW-1:0]          w_lim;
  logic                   w_last;
  logic [SCAN_BITS-1:0]   w_frame;
  always_comb begin
    w_lim   = r_state == IDLE ? TW'(GAP_TICKS - 1)
            : r_state == LOAD ? TW'(LOAD_TICKS - 1)
            : r_state == DONE ? '0
            : TW'(HALF_TICKS - 1);
    w_last  = r_tick == w_lim;
    w_frame = order_frame(r_sr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_sr     <= '0;
      r_prev   <= '0;
      r_joy1   <= '0;
      r_joy2   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (ce) begin
        r_tick <= w_last ? '0 : r_tick + TW'(1);
        case (r_state)
          IDLE: if (w_last) r_state <= LOAD;
          LOAD: begin
            r_bit <= '0;
            if (w_last) r_state <= SHIFT_LO;
          end
          SHIFT_LO: if (w_last) begin
            r_sr[r_bit] <= ~joyD;
            r_state     <= SHIFT_HI;
          end
          SHIFT_HI: if (w_last) begin
            r_state <= (r_bit == 4'(SCAN_BITS - 1)) ? DONE : SHIFT_LO;
            if (r_bit != 4'(SCAN_BITS - 1)) r_bit <= r_bit + 4'd1;
          end
          DONE: begin
            // Publish only when two consecutive scans agree.
            if (w_frame == r_prev) {r_joy2, r_joy1} <= w_frame;
            r_prev   <= w_frame;
            r_strobe <= 1'b1;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign joyLd  = r_state != LOAD;
  assign joyCk  = r_state == SHIFT_HI;
  assign joy1   = r_joy1;
  assign joy2   = r_joy2;
  assign strobe = r_strobe;
endmodule
